// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
// Includes the FSM state enum, LFSR polynomial and the BCD score helpers.
package whack_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_UP,
      S_DONE
   } state_e;

   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [3:0]  BCD_MAX   = 4'd9;
   localparam logic [7:0]  SCORE_SAT = 8'h99;

   // Score is packed as {tens, ones}; both helpers saturate instead of wrapping.
   function automatic logic [7:0] bcdInc(input logic [7:0] s);
      logic [7:0] r;
      r = s;
      if (s == SCORE_SAT) begin
         r = s;
      end else if (s[3:0] == BCD_MAX) begin
         r = {s[7:4] + 4'd1, 4'd0};
      end else begin
         r = {s[7:4], s[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcdDec(input logic [7:0] s);
      logic [7:0] r;
      r = s;
      if (s == 8'h00) begin
         r = s;
      end else if (s[3:0] == 4'd0) begin
         r = {s[7:4] - 4'd1, BCD_MAX};
      end else begin
         r = {s[7:4], s[3:0] - 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Galois LFSR (right-shifting, polynomial from whack_pkg).
// The low IDX_W bits of the current state serve as the raw mole index.
module whack_lfsr
   import whack_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          IDX_W = 2
) (
   input  logic             Clck_i,
   input  logic             reset_i,
   output logic [IDX_W-1:0] idx_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ LFSR_POLY;
      end
   end

   always_ff @(posedge Clck_i) begin
      if (reset_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign idx_o = lfsr_q[IDX_W-1:0];

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: game FSM, mole pacing, hit detection and BCD score.
// Define WHACK_MISS_PENALTY_EN to make wrong-key presses during UP cost one point.
module whack_game_ctrl
   import whack_pkg::*;
#(
   parameter int          NUM_MOLES       = 4,
   parameter int          MOLE_UP_CYCLES  = 50_000_000,
   parameter int          MOLE_GAP_CYCLES = 12_500_000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                 Clck_i,
   input  logic                 reset_i,
   input  logic                 start_key_i,
   input  logic [NUM_MOLES-1:0] whack_keys_i,
   input  logic                 timer_signal_i,
   output logic                 game_start_o,
   output logic                 game_done_o,
   output logic [NUM_MOLES-1:0] mole_leds_o,
   output logic [3:0]           score_ones_o,
   output logic [3:0]           score_tens_o
);

   localparam int          IDX_W    = $clog2(NUM_MOLES);
   localparam logic [26:0] GAP_LOAD = 27'(MOLE_GAP_CYCLES - 1);
   localparam logic [26:0] UP_LOAD  = 27'(MOLE_UP_CYCLES - 1);

   state_e               state_q, state_d;
   logic [26:0]          cnt_q, cnt_d;
   logic [7:0]           score_q, score_d;
   logic [NUM_MOLES-1:0] leds_q, leds_d;
   logic [IDX_W-1:0]     prevIdx_q, prevIdx_d;
   logic                 armed_q, armed_d;
   logic                 start_q, startPrev_q;
   logic [NUM_MOLES-1:0] keys_q, keysPrev_q;

   logic [IDX_W-1:0]     lfsrIdx;
   logic [IDX_W-1:0]     nextIdx;
   logic                 startEdge;
   logic [NUM_MOLES-1:0] keyEdge;
   logic                 hit;
   logic                 timeUp;

   whack_lfsr #(
      .SEED  (LFSR_SEED),
      .IDX_W (IDX_W)
   ) u_lfsr (
      .Clck_i  (Clck_i),
      .reset_i (reset_i),
      .idx_o   (lfsrIdx)
   );

   assign startEdge = start_q & ~startPrev_q;
   assign keyEdge   = keys_q & ~keysPrev_q;
   assign hit       = |(keyEdge & leds_q);
   assign timeUp    = armed_q & timer_signal_i;
   assign nextIdx   = (lfsrIdx == prevIdx_q) ? lfsrIdx + IDX_W'(1) : lfsrIdx;

`ifdef WHACK_MISS_PENALTY_EN
   logic miss;
   assign miss = |(keyEdge & ~leds_q);
`endif

   always_ff @(posedge Clck_i) begin
      if (reset_i) begin
         start_q     <= 1'b0;
         startPrev_q <= 1'b0;
         keys_q      <= '0;
         keysPrev_q  <= '0;
      end else begin
         start_q     <= start_key_i;
         startPrev_q <= start_q;
         keys_q      <= whack_keys_i;
         keysPrev_q  <= keys_q;
      end
   end

   always_ff @(posedge Clck_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         score_q   <= '0;
         leds_q    <= '0;
         prevIdx_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         score_q   <= score_d;
         leds_q    <= leds_d;
         prevIdx_q <= prevIdx_d;
         armed_q   <= armed_d;
      end
   end

   // Time-up outranks a hit; a timer level left high from the last game stays unarmed.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      score_d   = score_q;
      leds_d    = leds_q;
      prevIdx_d = prevIdx_q;
      armed_d   = armed_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (startEdge) begin
               state_d = S_GAP;
               score_d = '0;
               cnt_d   = GAP_LOAD;
               armed_d = 1'b0;
               leds_d  = '0;
            end
         end
         S_GAP: begin
            if (!timer_signal_i) begin
               armed_d = 1'b1;
            end
            if (timeUp) begin
               state_d = S_DONE;
               leds_d  = '0;
            end else if (cnt_q == '0) begin
               state_d         = S_UP;
               cnt_d           = UP_LOAD;
               leds_d          = '0;
               leds_d[nextIdx] = 1'b1;
               prevIdx_d       = nextIdx;
            end else begin
               cnt_d = cnt_q - 27'd1;
            end
         end
         S_UP: begin
            if (!timer_signal_i) begin
               armed_d = 1'b1;
            end
            if (timeUp) begin
               state_d = S_DONE;
               leds_d  = '0;
            end else if (hit) begin
               state_d = S_GAP;
               score_d = bcdInc(score_q);
               cnt_d   = GAP_LOAD;
               leds_d  = '0;
            end else begin
`ifdef WHACK_MISS_PENALTY_EN
               if (miss) begin
                  score_d = bcdDec(score_q);
               end
`endif
               if (cnt_q == '0) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LOAD;
                  leds_d  = '0;
               end else begin
                  cnt_d = cnt_q - 27'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign game_start_o = (state_q == S_GAP) || (state_q == S_UP);
   assign game_done_o  = (state_q == S_DONE);
   assign mole_leds_o  = leds_q;
   assign score_ones_o = score_q[3:0];
   assign score_tens_o = score_q[7:4];

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed self-checking bench for whack_game_ctrl (NUM_MOLES=4, UP=8, GAP=4).
// Honours WHACK_MISS_PENALTY_EN when computing the wrong-key expectation.
module tb_whack_game_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       startKey;
   logic [3:0] whackKeys;
   logic       timerSignal;
   logic       gameStart;
   logic       gameDone;
   logic [3:0] moleLeds;
   logic [3:0] scoreOnes;
   logic [3:0] scoreTens;

   int total = 0;
   int bad   = 0;
   int prevIdx = -1;
   int idx;
   logic [7:0] expScore;

   always #5 clk = ~clk;

   whack_game_ctrl #(
      .NUM_MOLES       (4),
      .MOLE_UP_CYCLES  (8),
      .MOLE_GAP_CYCLES (4),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .Clck_i         (clk),
      .reset_i        (reset),
      .start_key_i    (startKey),
      .whack_keys_i   (whackKeys),
      .timer_signal_i (timerSignal),
      .game_start_o   (gameStart),
      .game_done_o    (gameDone),
      .mole_leds_o    (moleLeds),
      .score_ones_o   (scoreOnes),
      .score_tens_o   (scoreTens)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ledIndex(input logic [3:0] l);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) begin
         if (l[i]) r = i;
      end
      return r;
   endfunction

   // Waits (bounded) for the next mole, then checks one-hot and no repeat.
   task automatic waitMole(output int i);
      for (int n = 0; n < 20; n++) begin
         tick();
         if (moleLeds != 4'b0000) break;
      end
      checkOutput("mole_onehot", {31'd0, $onehot(moleLeds)}, 32'd1);
      i = ledIndex(moleLeds);
      if (prevIdx >= 0) begin
         checkOutput("mole_distinct", {31'd0, (i != prevIdx)}, 32'd1);
      end
      prevIdx = i;
   endtask

   task automatic waitDrop;
      for (int n = 0; n < 20; n++) begin
         if (moleLeds == 4'b0000) break;
         tick();
      end
      checkOutput("mole_drop", {28'd0, moleLeds}, 32'd0);
   endtask

   task automatic applyStimulus(input logic [3:0] keys);
      whackKeys = keys;
      tick();
      tick();
      whackKeys = 4'b0000;
   endtask

   task automatic hitMole;
      int i;
      waitMole(i);
      applyStimulus(4'b0001 << i);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      startKey    = 1'b0;
      whackKeys   = 4'b0000;
      timerSignal = 1'b1;
      tick();
      tick();
      checkOutput("rst_start", {31'd0, gameStart}, 32'd0);
      checkOutput("rst_done",  {31'd0, gameDone},  32'd0);
      checkOutput("rst_leds",  {28'd0, moleLeds},  32'd0);
      checkOutput("rst_score", {24'd0, scoreTens, scoreOnes}, 32'h00);

      // Game 1: start with a stale-high timer level
      reset    = 1'b0;
      startKey = 1'b1;
      tick();
      checkOutput("start_lat", {31'd0, gameStart}, 32'd0);
      tick();
      checkOutput("start_on", {31'd0, gameStart}, 32'd1);
      checkOutput("gap_leds0", {28'd0, moleLeds}, 32'd0);
      startKey = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("gap_leds", {28'd0, moleLeds}, 32'd0);
      end
      tick();
      checkOutput("first_mole", {31'd0, $onehot(moleLeds)}, 32'd1);
      checkOutput("stale_timer", {31'd0, gameDone}, 32'd0);
      idx = ledIndex(moleLeds);
      prevIdx = idx;
      timerSignal = 1'b0;

      whackKeys = 4'b0001 << idx;
      tick();
      checkOutput("hit_lat_score", {24'd0, scoreTens, scoreOnes}, 32'h00);
      checkOutput("hit_lat_leds", {28'd0, moleLeds}, {28'd0, 4'b0001 << idx});
      tick();
      whackKeys = 4'b0000;
      checkOutput("hit_score", {24'd0, scoreTens, scoreOnes}, 32'h01);
      checkOutput("hit_leds", {28'd0, moleLeds}, 32'd0);

      // Unanswered mole stays up exactly 8 clocks
      waitMole(idx);
      repeat (7) tick();
      checkOutput("up_hold", {28'd0, moleLeds}, {28'd0, 4'b0001 << idx});
      tick();
      checkOutput("up_expire", {28'd0, moleLeds}, 32'd0);
      checkOutput("miss_score", {24'd0, scoreTens, scoreOnes}, 32'h01);

      for (int k = 0; k < 8; k++) hitMole();
      checkOutput("score_09", {24'd0, scoreTens, scoreOnes}, 32'h09);
      hitMole();
      checkOutput("score_10", {24'd0, scoreTens, scoreOnes}, 32'h10);
      for (int k = 0; k < 89; k++) hitMole();
      checkOutput("score_99", {24'd0, scoreTens, scoreOnes}, 32'h99);
      hitMole();
      checkOutput("score_sat", {24'd0, scoreTens, scoreOnes}, 32'h99);

      timerSignal = 1'b1;
      tick();
      checkOutput("tu_done",  {31'd0, gameDone},  32'd1);
      checkOutput("tu_start", {31'd0, gameStart}, 32'd0);
      checkOutput("tu_leds",  {28'd0, moleLeds},  32'd0);
      tick();
      checkOutput("done_score", {24'd0, scoreTens, scoreOnes}, 32'h99);

      // Game 2: restart from DONE, timer still high from the last game
      startKey = 1'b1;
      tick();
      tick();
      startKey = 1'b0;
      checkOutput("restart_on", {31'd0, gameStart}, 32'd1);
      checkOutput("restart_clr", {24'd0, scoreTens, scoreOnes}, 32'h00);
      repeat (3) tick();
      checkOutput("restart_stale", {31'd0, gameDone}, 32'd0);
      timerSignal = 1'b0;
      for (int k = 0; k < 3; k++) hitMole();
      checkOutput("score_03", {24'd0, scoreTens, scoreOnes}, 32'h03);

      waitMole(idx);
      applyStimulus(4'b0001 << ((idx + 1) % 4));
`ifdef WHACK_MISS_PENALTY_EN
      expScore = 8'h02;
`else
      expScore = 8'h03;
`endif
      checkOutput("wrong_key", {24'd0, scoreTens, scoreOnes}, {24'd0, expScore});
      checkOutput("wrong_leds", {28'd0, moleLeds}, {28'd0, 4'b0001 << idx});

      // Hit and time-up land in the same cycle
      waitDrop();
      waitMole(idx);
      whackKeys = 4'b0001 << idx;
      tick();
      timerSignal = 1'b1;
      tick();
      whackKeys = 4'b0000;
      checkOutput("tie_done",  {31'd0, gameDone}, 32'd1);
      checkOutput("tie_leds",  {28'd0, moleLeds}, 32'd0);
      checkOutput("tie_score", {24'd0, scoreTens, scoreOnes}, {24'd0, expScore});

      // Game 3: wrong key at 00, then reset while a mole is up
      startKey = 1'b1;
      tick();
      tick();
      startKey = 1'b0;
      timerSignal = 1'b0;
      checkOutput("g3_clr", {24'd0, scoreTens, scoreOnes}, 32'h00);
      waitMole(idx);
      applyStimulus(4'b0001 << ((idx + 1) % 4));
      checkOutput("wrong_at_00", {24'd0, scoreTens, scoreOnes}, 32'h00);
      checkOutput("g3_up", {28'd0, moleLeds}, {28'd0, 4'b0001 << idx});
      reset = 1'b1;
      tick();
      checkOutput("mid_rst_start", {31'd0, gameStart}, 32'd0);
      checkOutput("mid_rst_done",  {31'd0, gameDone},  32'd0);
      checkOutput("mid_rst_leds",  {28'd0, moleLeds},  32'd0);
      checkOutput("mid_rst_score", {24'd0, scoreTens, scoreOnes}, 32'h00);
      reset = 1'b0;
      tick();
      checkOutput("post_rst_idle", {31'd0, gameStart}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/whack_game_ctrl.md
# whack_game_ctrl

Game-control stage of the whack-a-mole design, directly upstream of the game timer. Owns the game state machine, drives the timer's `game_start` and `enable` (game done) inputs, and consumes its `timer_signal` (time up). Between start and time-up it pops one mole at a time on LEDs, detects player hits on debounced keys and keeps a two-digit BCD score ready for the hex decoders.

## Interface
- `NUM_MOLES`, 4: mole/key count; legal values 2, 4, 8.
- `MOLE_UP_CYCLES`, 50_000_000: clocks a mole stays up (27-bit counter).
- `MOLE_GAP_CYCLES`, 12_500_000: clocks between moles (27-bit counter).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `Clck` in 1: system clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `start_key` in 1: debounced start button, level.
- `whack_keys` in NUM_MOLES: debounced mole buttons, level, bit i = mole i.
- `timer_signal` in 1: time-up level from game timer.
- `game_start` out 1: high while playing; to timer `game_start`.
- `game_done` out 1: high in DONE; to timer `enable`.
- `mole_leds` out NUM_MOLES: one-hot active mole, or zero.
- `score_ones` out 4: BCD units.
- `score_tens` out 4: BCD tens.

## Operation
- Reset: state IDLE, all outputs 0, counter 0, LFSR = LFSR_SEED, key registers 0, timeout-armed flag 0.
- Input stage: `start_key`, `whack_keys` registered once; rising edge = registered & ~previous-registered.
- LFSR: 16-bit Galois, polynomial 0xB400, advances every clock in every state except reset.
- States: IDLE, GAP, UP, DONE. `game_start` = 1 in GAP/UP; `game_done` = 1 in DONE only.
- IDLE/DONE + start edge -> GAP; score cleared to 00; counter loaded; armed flag cleared.
- GAP: counter counts MOLE_GAP_CYCLES; at expiry -> UP with index = low log2(NUM_MOLES) LFSR bits; if index equals previous mole, use index+1 mod NUM_MOLES. `mole_leds` one-hot on entry.
- UP: edge on the active mole's key -> score +1, -> GAP. No hit by MOLE_UP_CYCLES -> GAP, score unchanged. Edge on other keys: see Configuration.
- Multiple key edges in one cycle: active-mole hit wins; at most one score change per cycle.
- Score: BCD increment, ones 9 -> 0 with tens carry; saturates at 99.
- Time-up: armed flag sets the first cycle `timer_signal` is sampled low in GAP/UP. `timer_signal` high while armed -> DONE. Unarmed `timer_signal` is ignored (stale level from the previous game).
- Time-up and hit in the same cycle: time-up wins, no score change.
- DONE: `mole_leds` 0, score held until next start edge.
- Start edge in GAP/UP: ignored.

## Timing
- Key high before edge k is registered at k; the state/score update occurs at edge k+1; visible after edge k+1 (2-clock latency).
- `mole_leds` and `game_start` are registered and change on the state-transition edge.
- `timer_signal` is used unregistered, 1-clock latency to DONE.
- GAP lasts exactly MOLE_GAP_CYCLES clocks and UP at most MOLE_UP_CYCLES clocks.
- Reset mid-game: next edge returns to IDLE, LEDs off, score 00.

## Configuration
- `WHACK_MISS_PENALTY_EN` defined: in UP, a non-active key edge with no hit decrements score (BCD borrow, saturates at 00); the mole stays up.
- Undefined: non-active key edges are ignored.

## Structure
- Package `whack_pkg`: state enum, LFSR polynomial 16'hB400, BCD max constant 4'd9, and score saturation value 99.
- Sub-module `whack_lfsr`: 16-bit Galois LFSR with seed parameter and index output.

## Test plan
- Reset, then NUM_MOLES=4, UP=8, GAP=4: start edge -> `game_start`=1 and GAP for 4 clocks, then exactly one `mole_leds` bit set.
- Press the active mole key -> score 01 two clocks after press and LEDs 0; press at 99 -> stays 99; press at 09 -> 10.
- No press -> mole drops after 8 clocks and score unchanged; consecutive mole indices are never equal.
- `timer_signal` held high at start -> game continues; low one cycle then high -> DONE, `game_done`=1, LEDs 0, score held; same-cycle hit not counted.
- Wrong key at score 03 -> 02 with macro, 03 without; at 00 -> 00.
- Reset asserted in UP -> IDLE next edge, all outputs 0; restart from DONE clears score.
